// File: rtl/demorgan_pkg.sv
// Shared constants and types for the De Morgan sweep controller.
// The unit's six outputs are bundled into one struct so the golden checker has a single input.
package demorgan_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int NUM_VECTORS = 4;
    localparam int NUM_CHECKS  = 6;

    // Field order matches the mismatch mask bit order, MSB first.
    typedef struct packed {
        logic n_a;
        logic n_b;
        logic n_a_and_n_b;
        logic n_a_or_b;
        logic n_a_or_n_b;
        logic n_a_and_b;
    } dm_obs_t;

endpackage

// File: rtl/demorgan_golden.sv
// Combinational golden model: compares the six observed unit outputs against
// the values expected for the current {a,b} drive.
module demorgan_golden
    import demorgan_pkg::*;
(
    input  logic                  a,
    input  logic                  b,
    input  dm_obs_t               obs,
    output logic [2:0]            mism_cnt,
    output logic [NUM_CHECKS-1:0] mism_mask
);

    logic e_nor;
    logic e_nand;

    always_comb begin
        e_nor     = ~(a | b);
        e_nand    = ~(a & b);
        mism_mask = {obs.n_a         ^ ~a,
                     obs.n_b         ^ ~b,
                     obs.n_a_and_n_b ^ e_nor,
                     obs.n_a_or_b    ^ e_nor,
                     obs.n_a_or_n_b  ^ e_nand,
                     obs.n_a_and_b   ^ e_nand};
        mism_cnt  = '0;
        for (int i = 0; i < NUM_CHECKS; i++)
            mism_cnt = mism_cnt + 3'(mism_mask[i]);
    end

endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// Drives all four {A,B} vectors into a De Morgan unit, samples its outputs after
// a settle interval and accumulates per-vector fail flags and a saturating error count.
module demorgan_sweep_ctrl
    import demorgan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             A,
    output logic             B,
    input  logic             nA,
    input  logic             nB,
    input  logic             nAandnB,
    input  logic             n_AorB,
    input  logic             nAornB,
    input  logic             n_AandB,
    output logic             busy,
    output logic             sample_valid,
    output logic [1:0]       sample_idx,
    output logic [3:0]       fail_vec,
    output logic [CNT_W-1:0] err_count,
    output logic             done,
    output logic             pass
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    logic [1:0]            state;
    logic [1:0]            idx;
    logic [SC_W-1:0]       settle_cnt;
    dm_obs_t               obs;
    logic [2:0]            mism_cnt;
    logic [NUM_CHECKS-1:0] mism_mask;
    logic [CNT_W:0]        err_sum;

    assign obs = '{n_a: nA, n_b: nB, n_a_and_n_b: nAandnB,
                   n_a_or_b: n_AorB, n_a_or_n_b: nAornB, n_a_and_b: n_AandB};

    demorgan_golden u_golden (
        .a         (A),
        .b         (B),
        .obs       (obs),
        .mism_cnt  (mism_cnt),
        .mism_mask (mism_mask)
    );

    // One extra bit catches the carry so the count can clamp at all-ones.
    assign err_sum = {1'b0, err_count} + (CNT_W+1)'(mism_cnt);
    assign busy    = (state == ST_SETTLE) || (state == ST_CHECK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            A            <= 1'b0;
            B            <= 1'b0;
            idx          <= '0;
            settle_cnt   <= '0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
            fail_vec     <= '0;
            err_count    <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        {A, B}     <= 2'b00;
                        settle_cnt <= '0;
                        fail_vec   <= '0;
                        err_count  <= '0;
                        pass       <= 1'b0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SC_LAST)
                        state <= ST_CHECK;
                    else
                        settle_cnt <= settle_cnt + 1'b1;
                end
                ST_CHECK: begin
                    err_count    <= err_sum[CNT_W] ? ERR_MAX : err_sum[CNT_W-1:0];
                    if (|mism_mask)
                        fail_vec[idx] <= 1'b1;
                    sample_valid <= 1'b1;
                    sample_idx   <= idx;
                    if (idx == 2'd3) begin
                        state <= ST_DONE;
                    end else begin
                        idx        <= idx + 2'd1;
                        {A, B}     <= idx + 2'd1;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    pass  <= (fail_vec == '0);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Directed bench for demorgan_sweep_ctrl: a behavioural De Morgan unit with
// injectable faults feeds one controller with SETTLE_CYCLES=1 and one with 3.
module tb_demorgan_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start3;
    int         fault;
    int         n_checks = 0;
    int         n_fail   = 0;

    logic       a1, b1, a3, b3;
    logic [5:0] u1, u3;
    logic       busy1, sv1, done1, pass1;
    logic       busy3, sv3, done3, pass3;
    logic [1:0] sidx1, sidx3;
    logic [3:0] fv1, fv3;
    logic [4:0] ec1, ec3;

    always #5 clk = ~clk;

    // Bit order {nA, nB, nAandnB, n_AorB, nAornB, n_AandB}
    function automatic logic [5:0] unit_model(input logic a, input logic b, input int f);
        logic [5:0] r;
        r = {~a, ~b, ~a & ~b, ~(a | b), ~a | ~b, ~(a & b)};
        if (f == 1) r[2] = 1'b0;
        if (f == 2) r[5] = a;
        if (f == 3) r[4] = 1'b1;
        return r;
    endfunction

    always_comb u1 = unit_model(a1, b1, fault);
    always_comb u3 = unit_model(a3, b3, fault);

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(5)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1),
        .nA(u1[5]), .nB(u1[4]), .nAandnB(u1[3]), .n_AorB(u1[2]), .nAornB(u1[1]), .n_AandB(u1[0]),
        .busy(busy1), .sample_valid(sv1), .sample_idx(sidx1), .fail_vec(fv1),
        .err_count(ec1), .done(done1), .pass(pass1)
    );

    demorgan_sweep_ctrl #(.SETTLE_CYCLES(3), .CNT_W(5)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .A(a3), .B(b3),
        .nA(u3[5]), .nB(u3[4]), .nAandnB(u3[3]), .n_AorB(u3[2]), .nAornB(u3[1]), .n_AandB(u3[0]),
        .busy(busy3), .sample_valid(sv3), .sample_idx(sidx3), .fail_vec(fv3),
        .err_count(ec3), .done(done3), .pass(pass3)
    );

    // One sweep on dut1 with a single start pulse; checks every cycle 0..9.
    task automatic run_sweep1(input string nm, input logic [3:0] exp_fv, input logic [4:0] exp_ec,
                              input logic exp_pass);
        logic [1:0] exp_ab;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_ab = (k / 2 > 3) ? 2'd3 : 2'(k / 2);
            n_checks++;
            if (sv1 !== (k >= 2 && k <= 8 && k % 2 == 0)) begin
                n_fail++; $display("FAIL %s sample_valid k=%0d got=%b", nm, k, sv1);
            end
            if (sv1 === 1'b1) begin
                n_checks++;
                if (sidx1 !== 2'(k / 2 - 1)) begin
                    n_fail++; $display("FAIL %s sample_idx k=%0d got=%0d want=%0d", nm, k, sidx1, k / 2 - 1);
                end
            end
            n_checks++;
            if (done1 !== (k == 9)) begin
                n_fail++; $display("FAIL %s done k=%0d got=%b", nm, k, done1);
            end
            n_checks++;
            if (busy1 !== (k <= 7)) begin
                n_fail++; $display("FAIL %s busy k=%0d got=%b", nm, k, busy1);
            end
            n_checks++;
            if ({a1, b1} !== exp_ab) begin
                n_fail++; $display("FAIL %s AB k=%0d got=%b%b want=%b", nm, k, a1, b1, exp_ab);
            end
        end
        n_checks++;
        if (fv1 !== exp_fv || ec1 !== exp_ec || pass1 !== exp_pass) begin
            n_fail++;
            $display("FAIL %s result got fv=%b ec=%0d pass=%b want fv=%b ec=%0d pass=%b",
                     nm, fv1, ec1, pass1, exp_fv, exp_ec, exp_pass);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start1 = 1'b0; start3 = 1'b0; fault = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a1, b1, busy1, sv1, sidx1, fv1, ec1, done1, pass1} !== '0) begin
            n_fail++; $display("FAIL reset_values got A=%b B=%b busy=%b sv=%b idx=%0d fv=%b ec=%0d done=%b pass=%b",
                               a1, b1, busy1, sv1, sidx1, fv1, ec1, done1, pass1);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_correct_unit();
        fault = 0;
        run_sweep1("correct", 4'b0000, 5'd0, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_faults();
        fault = 1;
        run_sweep1("nor_stuck0", 4'b0001, 5'd1, 1'b0);
        @(posedge clk); #1;
        fault = 2;
        run_sweep1("na_no_inv", 4'b1111, 5'd4, 1'b0);
        @(posedge clk); #1;
        fault = 0;
        // Results must hold steady while idle.
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (fv1 !== 4'b1111 || ec1 !== 5'd4 || pass1 !== 1'b0) begin
            n_fail++; $display("FAIL hold_results got fv=%b ec=%0d pass=%b", fv1, ec1, pass1);
        end
    endtask

    task automatic test_settle3();
        int ndone = 0;
        logic [1:0] exp_ab;
        fault = 0;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 5) start3 = 1'b1;
            if (k == 6) start3 = 1'b0;
            exp_ab = (k / 4 > 3) ? 2'd3 : 2'(k / 4);
            if (done3 === 1'b1) ndone++;
            n_checks++;
            if (sv3 !== (k >= 4 && k <= 16 && k % 4 == 0)) begin
                n_fail++; $display("FAIL settle3 sample_valid k=%0d got=%b", k, sv3);
            end
            if (sv3 === 1'b1) begin
                n_checks++;
                if (sidx3 !== 2'(k / 4 - 1)) begin
                    n_fail++; $display("FAIL settle3 sample_idx k=%0d got=%0d", k, sidx3);
                end
            end
            n_checks++;
            if (done3 !== (k == 17)) begin
                n_fail++; $display("FAIL settle3 done k=%0d got=%b", k, done3);
            end
            n_checks++;
            if ({a3, b3} !== exp_ab) begin
                n_fail++; $display("FAIL settle3 AB k=%0d got=%b%b want=%b", k, a3, b3, exp_ab);
            end
        end
        n_checks++;
        if (ndone != 1 || fv3 !== 4'b0000 || ec3 !== 5'd0 || pass3 !== 1'b1) begin
            n_fail++; $display("FAIL settle3 result ndone=%0d fv=%b ec=%0d pass=%b want 1 0000 0 1",
                               ndone, fv3, ec3, pass3);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int ndone = 0;
        fault = 2;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        // Now in SETTLE for vector 2, with a mismatch already recorded.
        reset = 1'b1;
        #1;
        n_checks++;
        if ({a1, b1, busy1, sv1, sidx1, fv1, ec1, done1, pass1} !== '0) begin
            n_fail++; $display("FAIL async_reset got A=%b B=%b busy=%b fv=%b ec=%0d done=%b pass=%b",
                               a1, b1, busy1, fv1, ec1, done1, pass1);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) ndone++;
        end
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0) begin
            n_fail++; $display("FAIL reset_no_done got=%0d want=0", ndone);
        end
        fault = 0;
        run_sweep1("after_reset", 4'b0000, 5'd0, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        fault = 0;
        start1 = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 9) begin
                n_checks++;
                if (fv1 !== 4'b0000 || ec1 !== 5'd0 || pass1 !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_first got fv=%b ec=%0d pass=%b", fv1, ec1, pass1);
                end
                fault = 3;
            end
            if (k == 10) begin
                start1 = 1'b0;
                n_checks++;
                if (fv1 !== 4'b0000 || ec1 !== 5'd0 || pass1 !== 1'b0 || busy1 !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_clear got fv=%b ec=%0d pass=%b busy=%b want 0000 0 0 1",
                                       fv1, ec1, pass1, busy1);
                end
            end
            n_checks++;
            if (done1 !== (k == 9 || k == 19)) begin
                n_fail++; $display("FAIL b2b_done k=%0d got=%b", k, done1);
            end
        end
        n_checks++;
        if (fv1 !== 4'b1010 || ec1 !== 5'd2 || pass1 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second got fv=%b ec=%0d pass=%b want fv=1010 ec=2 pass=0",
                               fv1, ec1, pass1);
        end
        fault = 0;
    endtask

    initial begin
        test_reset();
        test_correct_unit();
        test_faults();
        test_settle3();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
